// File: rtl/div_input_stage_pkg.sv
// Shared types and constants for the divider issue stage: operand width,
// divide-group funct3 encodings and the packed request handed to the divider.
package div_input_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] DIV_fn3  = 3'b100;
    localparam logic [2:0] DIVU_fn3 = 3'b101;
    localparam logic [2:0] REM_fn3  = 3'b110;
    localparam logic [2:0] REMU_fn3 = 3'b111;

    // Most negative signed value; with a divisor of -1 it overflows signed division
    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [1:0]      op;
        logic            reuse_result;
        logic            div_zero;
        logic            overflow;
    } div_inputs_t;

endpackage

// File: rtl/div_input_stage_if.sv
// Issue-side and divider-side handshake bundle for the divider issue stage.
// slave = the stage itself, master = the decode/divider environment driving it.
interface div_input_stage_if;
    import div_input_stage_pkg::*;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [2:0]            issue_fn3;
    logic [XLEN-1:0]       issue_rs1;
    logic [XLEN-1:0]       issue_rs2;
    logic                  div_ready;
    logic                  div_request;
    div_inputs_t           div_inputs;

    modport slave (
        input  issue_valid, issue_fn3, issue_rs1, issue_rs2, div_ready,
        output issue_ready, div_request, div_inputs
    );

    modport master (
        output issue_valid, issue_fn3, issue_rs1, issue_rs2, div_ready,
        input  issue_ready, div_request, div_inputs
    );

endinterface

// File: rtl/div_operand_record.sv
// Remembers the operands of the last op that actually starts the divider and
// flags a new op whose quotient/remainder can be taken from that run.
module div_operand_record
    import div_input_stage_pkg::*;
#(
    parameter bit REUSE_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            accept,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            signed_op,
    input  logic            div_zero,
    input  logic            overflow,
    output logic            reuse_result
);

    logic            rec_valid_q, rec_valid_d;
    logic [XLEN-1:0] rec_rs1_q, rec_rs1_d;
    logic [XLEN-1:0] rec_rs2_q, rec_rs2_d;
    logic            rec_signed_q, rec_signed_d;
    logic            match;
    logic            update;

    always_comb begin
        match = rec_valid_q & (rs1 == rec_rs1_q) & (rs2 == rec_rs2_q)
              & (signed_op == rec_signed_q);
        reuse_result = REUSE_ENABLE & match & ~div_zero & ~overflow;
        // Aborting and reusing ops never touch the divider's Q/R, so the record must not follow them
        update = REUSE_ENABLE & accept & ~div_zero & ~overflow & ~reuse_result;

        rec_valid_d  = rec_valid_q;
        rec_rs1_d    = rec_rs1_q;
        rec_rs2_d    = rec_rs2_q;
        rec_signed_d = rec_signed_q;
        if (update) begin
            rec_valid_d  = 1'b1;
            rec_rs1_d    = rs1;
            rec_rs2_d    = rs2;
            rec_signed_d = signed_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_valid_q  <= 1'b0;
            rec_rs1_q    <= '0;
            rec_rs2_q    <= '0;
            rec_signed_q <= 1'b0;
        end else begin
            rec_valid_q  <= rec_valid_d;
            rec_rs1_q    <= rec_rs1_d;
            rec_rs2_q    <= rec_rs2_d;
            rec_signed_q <= rec_signed_d;
        end
    end

endmodule

// File: rtl/div_input_stage.sv
// Registered issue stage in front of the divider: computes abort/reuse flags at
// accept and feeds the divider FIFO through a 2-entry skid buffer.
module div_input_stage
    import div_input_stage_pkg::*;
#(
    parameter bit REUSE_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    div_input_stage_if.slave  io
);

    logic        head_valid_q, head_valid_d;
    logic        skid_valid_q, skid_valid_d;
    div_inputs_t head_q, head_d;
    div_inputs_t skid_q, skid_d;
    logic        issue_ready_q, issue_ready_d;

    logic        accept;
    logic        drain;
    logic        signed_op;
    logic        div_zero;
    logic        overflow;
    logic        reuse_result;
    logic        fn3_unused;
    div_inputs_t entry_in;

    // funct3[2] is constant across the divide group and carries no information here
    assign fn3_unused = io.issue_fn3[2];

    assign accept    = io.issue_valid & issue_ready_q;
    assign drain     = head_valid_q & io.div_ready;
    assign signed_op = ~io.issue_fn3[0];
    assign div_zero  = (io.issue_rs2 == '0);
    assign overflow  = signed_op & (io.issue_rs1 == SIGNED_MIN) & (io.issue_rs2 == '1);

    div_operand_record #(
        .REUSE_ENABLE (REUSE_ENABLE)
    ) u_record (
        .clk          (clk),
        .rst          (rst),
        .accept       (accept),
        .rs1          (io.issue_rs1),
        .rs2          (io.issue_rs2),
        .signed_op    (signed_op),
        .div_zero     (div_zero),
        .overflow     (overflow),
        .reuse_result (reuse_result)
    );

    always_comb begin
        entry_in.rs1          = io.issue_rs1;
        entry_in.rs2          = io.issue_rs2;
        entry_in.op           = io.issue_fn3[1:0];
        entry_in.reuse_result = reuse_result;
        entry_in.div_zero     = div_zero;
        entry_in.overflow     = overflow;
    end

    always_comb begin
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_d       = head_q;
        skid_d       = skid_q;

        if (drain) begin
            // Accept is impossible while skid is occupied, so only one source can refill the head
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                head_d = entry_in;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (head_valid_q) begin
                skid_d       = entry_in;
                skid_valid_d = 1'b1;
            end else begin
                head_d       = entry_in;
                head_valid_d = 1'b1;
            end
        end

        issue_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_q  <= 1'b0;
            skid_valid_q  <= 1'b0;
            head_q        <= '0;
            skid_q        <= '0;
            issue_ready_q <= 1'b1;
        end else begin
            head_valid_q  <= head_valid_d;
            skid_valid_q  <= skid_valid_d;
            head_q        <= head_d;
            skid_q        <= skid_d;
            issue_ready_q <= issue_ready_d;
        end
    end

    assign io.issue_ready = issue_ready_q;
    assign io.div_request = drain & ~rst;
    assign io.div_inputs  = head_valid_q ? head_q : '0;

endmodule

// File: tb/tb_div_input_stage.sv
// Directed bench for div_input_stage: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge.
module tb_div_input_stage;
    import div_input_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_input_stage_if bus ();

    div_input_stage #(
        .REUSE_ENABLE (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    function automatic div_inputs_t mk(logic [31:0] a, logic [31:0] b, logic [1:0] op,
                                       logic reuse, logic dz, logic ov);
        div_inputs_t e;
        e.rs1 = a; e.rs2 = b; e.op = op;
        e.reuse_result = reuse; e.div_zero = dz; e.overflow = ov;
        return e;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input div_inputs_t obs, input div_inputs_t exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid = v;
        bus.issue_fn3   = f;
        bus.issue_rs1   = a;
        bus.issue_rs2   = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.div_ready = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        bus.div_ready = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            sample();
            chk1("idle_ready", bus.issue_ready, 1'b1);
            chk1("idle_req", bus.div_request, 1'b0);
            chkv("idle_inputs", bus.div_inputs, '0);
            step();
        end

        // 2: DIV 20/3 then REM 20/3
        drive(1'b1, DIV_fn3, 32'd20, 32'd3);
        sample();
        chk1("t2_no_req_same_cycle", bus.div_request, 1'b0);
        step();
        drive(1'b1, REM_fn3, 32'd20, 32'd3);
        sample();
        chk1("t2_req1", bus.div_request, 1'b1);
        chkv("t2_div", bus.div_inputs, mk(32'd20, 32'd3, 2'b00, 1'b0, 1'b0, 1'b0));
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        sample();
        chk1("t2_req2", bus.div_request, 1'b1);
        chkv("t2_rem_reuse", bus.div_inputs, mk(32'd20, 32'd3, 2'b10, 1'b1, 1'b0, 1'b0));
        step();
        sample();
        chk1("t2_req_done", bus.div_request, 1'b0);
        chkv("t2_empty", bus.div_inputs, '0);
        step();

        // 3: overflow, then 7/2 twice
        drive(1'b1, DIV_fn3, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        drive(1'b1, DIV_fn3, 32'd7, 32'd2);
        sample();
        chkv("t3_overflow", bus.div_inputs, mk(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0, 1'b1));
        step();
        drive(1'b1, DIV_fn3, 32'd7, 32'd2);
        sample();
        chkv("t3_first_7_2", bus.div_inputs, mk(32'd7, 32'd2, 2'b00, 1'b0, 1'b0, 1'b0));
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        sample();
        chkv("t3_second_7_2", bus.div_inputs, mk(32'd7, 32'd2, 2'b00, 1'b1, 1'b0, 1'b0));
        step();

        // 4: REMU by zero twice
        drive(1'b1, REMU_fn3, 32'd5, 32'd0);
        step();
        drive(1'b1, REMU_fn3, 32'd5, 32'd0);
        sample();
        chkv("t4_dz1", bus.div_inputs, mk(32'd5, 32'd0, 2'b11, 1'b0, 1'b1, 1'b0));
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        sample();
        chkv("t4_dz2", bus.div_inputs, mk(32'd5, 32'd0, 2'b11, 1'b0, 1'b1, 1'b0));
        step();
        sample();
        chk1("t4_req_done", bus.div_request, 1'b0);
        step();

        // 5: stall with three ops, then release
        bus.div_ready = 1'b0;
        drive(1'b1, DIVU_fn3, 32'd100, 32'd7);
        step();
        drive(1'b1, DIVU_fn3, 32'd9, 32'd3);
        sample();
        chk1("t5_ready_after1", bus.issue_ready, 1'b1);
        chk1("t5_req_stalled", bus.div_request, 1'b0);
        chkv("t5_head_a", bus.div_inputs, mk(32'd100, 32'd7, 2'b01, 1'b0, 1'b0, 1'b0));
        step();
        drive(1'b1, REM_fn3, 32'd1, 32'd1);
        sample();
        chk1("t5_ready_after2", bus.issue_ready, 1'b0);
        step();
        bus.div_ready = 1'b1;
        sample();
        chk1("t5_ready_held", bus.issue_ready, 1'b0);
        chk1("t5_push_a", bus.div_request, 1'b1);
        chkv("t5_push_a_data", bus.div_inputs, mk(32'd100, 32'd7, 2'b01, 1'b0, 1'b0, 1'b0));
        step();
        sample();
        chk1("t5_ready_back", bus.issue_ready, 1'b1);
        chk1("t5_push_b", bus.div_request, 1'b1);
        chkv("t5_push_b_data", bus.div_inputs, mk(32'd9, 32'd3, 2'b01, 1'b0, 1'b0, 1'b0));
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        sample();
        chk1("t5_push_c", bus.div_request, 1'b1);
        chkv("t5_push_c_data", bus.div_inputs, mk(32'd1, 32'd1, 2'b10, 1'b0, 1'b0, 1'b0));
        step();
        sample();
        chk1("t5_drained", bus.div_request, 1'b0);
        chkv("t5_empty", bus.div_inputs, '0);
        step();

        // 6: signedness breaks reuse
        drive(1'b1, DIV_fn3, 32'hFFFF_FFFA, 32'd4);
        step();
        drive(1'b1, DIVU_fn3, 32'hFFFF_FFFA, 32'd4);
        sample();
        chkv("t6_div_signed", bus.div_inputs, mk(32'hFFFF_FFFA, 32'd4, 2'b00, 1'b0, 1'b0, 1'b0));
        step();
        drive(1'b1, DIVU_fn3, 32'hFFFF_FFFA, 32'd4);
        sample();
        chkv("t6_divu_no_reuse", bus.div_inputs, mk(32'hFFFF_FFFA, 32'd4, 2'b01, 1'b0, 1'b0, 1'b0));
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        sample();
        chkv("t6_divu_reuse", bus.div_inputs, mk(32'hFFFF_FFFA, 32'd4, 2'b01, 1'b1, 1'b0, 1'b0));
        step();

        // 7: reset while stalled and full
        bus.div_ready = 1'b0;
        drive(1'b1, DIVU_fn3, 32'hFFFF_FFFA, 32'd4);
        step();
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        sample();
        chk1("t7_full", bus.issue_ready, 1'b0);
        step();
        rst = 1'b1;
        bus.div_ready = 1'b1;
        sample();
        chk1("t7_no_push_in_reset", bus.div_request, 1'b0);
        step();
        rst = 1'b0;
        sample();
        chk1("t7_ready_after_rst", bus.issue_ready, 1'b1);
        chk1("t7_req_after_rst", bus.div_request, 1'b0);
        chkv("t7_empty_after_rst", bus.div_inputs, '0);
        step();
        drive(1'b1, DIVU_fn3, 32'hFFFF_FFFA, 32'd4);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        sample();
        chk1("t7_req_new", bus.div_request, 1'b1);
        chkv("t7_record_cleared", bus.div_inputs, mk(32'hFFFF_FFFA, 32'd4, 2'b01, 1'b0, 1'b0, 1'b0));
        step();
        sample();
        chk1("t7_drained", bus.div_request, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
